// File: rtl/div_ram_arbiter.sv
// rtl/div_ram_arbiter.sv - two-writer/one-reader RAM front end with round-robin grant and sweep clear
// Reads run alongside writes; a same-cycle read/write collision is resolved write-first via a bypass.
module div_ram_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  async_clear_n,
  input  logic                  wa_valid,
  output logic                  wa_ready,
  input  logic [ADDR_WIDTH-1:0] wa_addr,
  input  logic [DATA_WIDTH-1:0] wa_data,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_b;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_rvalid;
  logic                  r_done;
  logic                  r_byp_hit;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_rd_accept;
  logic                  w_sweep_end;

  // Grants are masked during reset so no RAM write can slip out while async_clear_n is low.
  always_comb begin
    w_next_state   = r_state;
    w_grant_a      = 1'b0;
    w_grant_b      = 1'b0;
    rd_ready       = 1'b0;
    ram_we         = 1'b0;
    ram_write_addr = wa_addr;
    ram_data       = wa_data;
    case (r_state)
      IDLE: begin
        rd_ready = 1'b1;
        if (async_clear_n) begin
          if (wa_valid && (!wb_valid || r_last_b)) w_grant_a = 1'b1;
          else if (wb_valid)                       w_grant_b = 1'b1;
        end
        ram_we = w_grant_a | w_grant_b;
        if (w_grant_b) begin
          ram_write_addr = wb_addr;
          ram_data       = wb_data;
        end
        if (clr_start) w_next_state = CLEAR;
      end
      CLEAR: begin
        ram_we         = async_clear_n;
        ram_write_addr = r_count;
        ram_data       = '0;
        if (r_count == LAST_ADDR) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign wa_ready      = w_grant_a;
  assign wb_ready      = w_grant_b;
  assign w_rd_accept   = rd_valid & rd_ready;
  assign w_sweep_end   = (r_state == CLEAR) && (r_count == LAST_ADDR);
  assign ram_read_addr = rd_addr;
  assign rd_rvalid     = r_rvalid;
  assign rd_rdata      = r_byp_hit ? r_byp_data : ram_q;
  assign clr_busy      = (r_state == CLEAR);
  assign clr_done      = r_done;

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_last_b   <= 1'b1;
      r_rvalid   <= 1'b0;
      r_done     <= 1'b0;
      r_byp_hit  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == CLEAR) r_count <= r_count + 1'b1;
      else                  r_count <= '0;
      if (w_grant_a)      r_last_b <= 1'b0;
      else if (w_grant_b) r_last_b <= 1'b1;
      r_rvalid   <= w_rd_accept;
      r_done     <= w_sweep_end;
      r_byp_hit  <= w_rd_accept && ram_we && (ram_write_addr == rd_addr);
      r_byp_data <= ram_data;
    end
  end

endmodule

// File: tb/tb_div_ram_arbiter.sv
// tb/tb_div_ram_arbiter.sv - scoreboard bench for div_ram_arbiter with a read-first RAM model
module tb_div_ram_arbiter;

  localparam int DW    = 2;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          async_clear_n = 1'b0;
  logic          wa_valid = 1'b0, wb_valid = 1'b0, rd_valid = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] wa_addr = '0, wb_addr = '0, rd_addr = '0;
  logic [DW-1:0] wa_data = '0, wb_data = '0;
  logic          wa_ready, wb_ready, rd_ready, rd_rvalid, clr_busy, clr_done, ram_we;
  logic [DW-1:0] rd_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q_r;
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_exp_t;
  rd_exp_t rq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  div_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .async_clear_n(async_clear_n),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q_r <= mem[ram_read_addr];
  end
  assign ram_q = ram_q_r;

  always @(posedge clk) cyc <= cyc + 1;

  // Read scoreboard: each accepted read is due exactly one cycle after acceptance.
  always @(negedge clk) begin
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      n_vec++;
      if (rd_rvalid !== 1'b1 || rd_rdata !== rq[0].data) begin
        n_err++;
        $display("FAIL read_data cyc=%0d got rvalid=%b data=%b want rvalid=1 data=%b",
                 cyc, rd_rvalid, rd_rdata, rq[0].data);
      end
      void'(rq.pop_front());
    end else if (rd_rvalid === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL read_unexpected cyc=%0d got rvalid=1 want rvalid=0", cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wa_valid  = 1'b0;
    wb_valid  = 1'b0;
    rd_valid  = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic test_reset;
    async_clear_n = 1'b0;
    idle_inputs();
    wa_valid = 1'b1; wa_addr = 7'd3; wa_data = 2'b01;
    repeat (2) tick();
    n_vec++;
    if ({ram_we, clr_busy, clr_done, rd_rvalid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state got we/busy/done/rvalid=%b want 0000",
               {ram_we, clr_busy, clr_done, rd_rvalid});
    end
    wa_valid = 1'b0;
    async_clear_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin;
    bit va[9]  = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
    bit vb[9]  = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
    bit ega[9] = '{1, 0, 1, 0, 0, 1, 1, 0, 0};
    bit egb[9] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int i = 0; i < 9; i++) begin
      wa_valid = va[i]; wa_addr = 7'(10 + i); wa_data = 2'(i);
      wb_valid = vb[i]; wb_addr = 7'(30 + i); wb_data = ~2'(i);
      #1;
      ea = ega[i] ? wa_addr : wb_addr;
      ed = ega[i] ? wa_data : wb_data;
      n_vec++;
      if (wa_ready !== ega[i] || wb_ready !== egb[i] || ram_we !== (ega[i] | egb[i])) begin
        n_err++;
        $display("FAIL rr_grant step=%0d got a/b/we=%b%b%b want %b%b%b", i,
                 wa_ready, wb_ready, ram_we, ega[i], egb[i], ega[i] | egb[i]);
      end
      if (ega[i] | egb[i]) begin
        n_vec++;
        if (ram_write_addr !== ea || ram_data !== ed) begin
          n_err++;
          $display("FAIL rr_payload step=%0d got addr=%0d data=%b want addr=%0d data=%b",
                   i, ram_write_addr, ram_data, ea, ed);
        end
        ref_mem[ea] = ed;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_first;
    wa_valid = 1'b1; wa_addr = 7'd5; wa_data = 2'b01;
    tick();
    wa_data = 2'b11; rd_valid = 1'b1; rd_addr = 7'd5;
    ref_mem[5] = 2'b11;
    #1;
    n_vec++;
    if (rd_ready !== 1'b1 || ram_read_addr !== 7'd5 || ram_we !== 1'b1) begin
      n_err++;
      $display("FAIL wf_accept got rd_ready=%b raddr=%0d we=%b want 1 5 1", rd_ready, ram_read_addr, ram_we);
    end
    rq.push_back('{data: ref_mem[5], cyc: cyc + 1});
    tick();
    wa_valid = 1'b0; wb_valid = 1'b1; wb_addr = 7'd6; wb_data = 2'b10; rd_addr = 7'd10;
    ref_mem[6] = 2'b10;
    rq.push_back('{data: ref_mem[10], cyc: cyc + 1});
    tick();
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_clear;
    int n_busy;
    for (int a = 0; a < DEPTH; a++) begin
      wa_valid = 1'b1; wa_addr = 7'(a); wa_data = 2'b10;
      ref_mem[a] = 2'b10;
      tick();
    end
    wa_addr = 7'd7; wa_data = 2'b01; rd_valid = 1'b1; rd_addr = 7'd3; clr_start = 1'b1;
    #1;
    n_vec++;
    if (wa_ready !== 1'b1 || ram_we !== 1'b1 || ram_write_addr !== 7'd7 || clr_busy !== 1'b0) begin
      n_err++;
      $display("FAIL clr_start_write got ready=%b we=%b addr=%0d busy=%b want 1 1 7 0",
               wa_ready, ram_we, ram_write_addr, clr_busy);
    end
    rq.push_back('{data: ref_mem[3], cyc: cyc + 1});
    tick();
    clr_start = 1'b0; wb_valid = 1'b1; wb_addr = 7'd9;
    n_busy = 0;
    for (int k = 0; k < 300; k++) begin
      if (clr_busy !== 1'b1) break;
      n_vec++;
      if ({wa_ready, wb_ready, rd_ready, ram_we} !== 4'b0001 || ram_data !== 2'b00 ||
          ram_write_addr !== 7'(n_busy)) begin
        n_err++;
        $display("FAIL sweep_cycle n=%0d got rdy_a/b/r/we=%b addr=%0d data=%b want 0001 addr=%0d data=00",
                 n_busy, {wa_ready, wb_ready, rd_ready, ram_we}, ram_write_addr, ram_data, n_busy);
      end
      clr_start = (n_busy == 60);
      n_busy++;
      tick();
    end
    idle_inputs();
    n_vec++;
    if (n_busy != DEPTH || clr_done !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_len got busy_cycles=%0d done=%b want %0d 1", n_busy, clr_done, DEPTH);
    end
    tick();
    n_vec++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse got done=%b busy=%b want 0 0", clr_done, clr_busy);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 2'b00;
    for (int a = 0; a < DEPTH; a++) begin
      rd_valid = 1'b1; rd_addr = 7'(a);
      rq.push_back('{data: ref_mem[a], cyc: cyc + 1});
      tick();
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_reset_abort;
    for (int a = 0; a < DEPTH; a++) begin
      wb_valid = 1'b1; wb_addr = 7'(a); wb_data = 2'b10;
      ref_mem[a] = 2'b10;
      tick();
    end
    idle_inputs();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (40) tick();
    n_vec++;
    if (clr_busy !== 1'b1 || ram_write_addr !== 7'd40) begin
      n_err++;
      $display("FAIL abort_point got busy=%b addr=%0d want 1 40", clr_busy, ram_write_addr);
    end
    async_clear_n = 1'b0;
    #1;
    n_vec++;
    if (clr_busy !== 1'b0 || ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL abort_immediate got busy=%b we=%b want 0 0", clr_busy, ram_we);
    end
    for (int a = 0; a < 40; a++) ref_mem[a] = 2'b00;
    repeat (3) tick();
    async_clear_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_done k=%0d got done=%b busy=%b want 0 0", k, clr_done, clr_busy);
      end
      tick();
    end
    for (int a = 38; a < 42; a++) begin
      rd_valid = 1'b1; rd_addr = 7'(a);
      rq.push_back('{data: ref_mem[a], cyc: cyc + 1});
      tick();
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_back_to_back;
    bit ga, gb, exp_last_b;
    exp_last_b = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wa_valid = 1'($urandom_range(0, 1)); wa_addr = 7'($urandom_range(0, 7)); wa_data = 2'($urandom);
      wb_valid = 1'($urandom_range(0, 1)); wb_addr = 7'($urandom_range(0, 7)); wb_data = 2'($urandom);
      rd_valid = 1'($urandom_range(0, 1)); rd_addr = 7'($urandom_range(0, 7));
      ga = wa_valid && (!wb_valid || exp_last_b);
      gb = wb_valid && !ga;
      #1;
      n_vec++;
      if (wa_ready !== ga || wb_ready !== gb || ram_we !== (ga | gb) ||
          (ga && (ram_write_addr !== wa_addr || ram_data !== wa_data)) ||
          (gb && (ram_write_addr !== wb_addr || ram_data !== wb_data))) begin
        n_err++;
        $display("FAIL b2b_write i=%0d got a/b/we=%b%b%b addr=%0d data=%b want %b%b%b", i,
                 wa_ready, wb_ready, ram_we, ram_write_addr, ram_data, ga, gb, ga | gb);
      end
      if (ga) begin ref_mem[wa_addr] = wa_data; exp_last_b = 1'b0; end
      if (gb) begin ref_mem[wb_addr] = wb_data; exp_last_b = 1'b1; end
      if (rd_valid) rq.push_back('{data: ref_mem[rd_addr], cyc: cyc + 1});
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 2'b00;
    test_reset();
    test_round_robin();
    test_write_first();
    test_clear();
    test_reset_abort();
    test_back_to_back();
    n_vec++;
    if (rq.size() != 0) begin
      n_err++;
      $display("FAIL read_drain got pending=%0d want 0", rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
